// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory-access stage.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  // Control fields of the in-flight access, held from accept until retire.
  // size is kept raw (2 bits) so that the encoding 3 reaches the word path.
  typedef struct packed {
    logic       is_load;
    logic       zero_ext;
    logic       misalign;
    logic [1:0] size;
    logic [4:0] rd;
  } req_ctrl_t;

endpackage

// File: rtl/lsu_mem_access_align.sv
// Byte-lane steering: store strobes, store data replication and
// load extraction/extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic            zero_ext_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ld_data_o
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte/half down to bit 0; words arrive with off_i = 0.
  assign shifted = ld_word_i >> {off_i, 3'b000};

  // Per-size lane selection; size 3 falls into the word path.
  always_comb begin
    wstrb_o   = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = shifted;
    case (size_i)
      SZ_B: begin
        wstrb_o   = 4'b0001 << off_i;
        wdata_o   = {(XLEN/8){st_data_i[7:0]}};
        ld_data_o = zero_ext_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                               : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wstrb_o   = 4'b0011 << off_i;
        wdata_o   = {(XLEN/16){st_data_i[15:0]}};
        ld_data_o = zero_ext_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                               : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wstrb_o   = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: effective address, single-outstanding word
// request, load alignment and writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word raise
// exc_valid instead of being force-aligned and issued).
//
// state   | meaning
// IDLE    | ready for a new decoded instruction
// REQ     | memory request presented, waiting for mem_req_ready
// RSP     | request accepted, waiting for mem_rsp_valid
// WB      | one-cycle writeback (or exception) pulse
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_zero_ext,
  input  logic              in_is_nop,
  input  logic [1:0]        in_size,
  input  logic [XLEN-1:0]   in_rs1_val,
  input  logic [XLEN-1:0]   in_rs2_val,
  input  logic [4:0]        in_rd,
  input  logic [11:0]       in_imm,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_addr
);

  state_e            state_q, state_d;
  req_ctrl_t         ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [XLEN-1:0]   ea_full;
  logic [1:0]        off_eff;
  logic              misalign_in;
  logic [3:0]        strb_raw;
  logic [XLEN-1:0]   ld_data;

  assign ea_full = in_rs1_val + {{(XLEN-12){in_imm[11]}}, in_imm};

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] in_off;
  assign in_off = ea_full[1:0];

  // Flag accesses that cannot be served by one naturally aligned lane group.
  always_comb begin
    misalign_in = 1'b0;
    case (in_size)
      SZ_B:    misalign_in = 1'b0;
      SZ_H:    misalign_in = in_off[0];
      default: misalign_in = (in_off != 2'b00);
    endcase
  end

  // Only aligned accesses are issued, so the raw offset is already natural.
  assign off_eff   = ea_q[1:0];
  assign exc_valid = (state_q == ST_WB) && ctrl_q.misalign;
  assign exc_addr  = ea_q;
`else
  assign misalign_in = 1'b0;

  // Drop the offset bits that a half or word cannot use (forced alignment).
  always_comb begin
    off_eff = ea_q[1:0];
    case (ctrl_q.size)
      SZ_B:    off_eff = ea_q[1:0];
      SZ_H:    off_eff = {ea_q[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

  assign exc_valid = 1'b0;
  assign exc_addr  = '0;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .size_i     (ctrl_q.size),
    .off_i      (off_eff),
    .zero_ext_i (ctrl_q.zero_ext),
    .st_data_i  (wdata_q),
    .ld_word_i  (mem_rdata),
    .wstrb_o    (strb_raw),
    .wdata_o    (mem_wdata),
    .ld_data_o  (ld_data)
  );

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      ea_q      <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      ea_q      <= ea_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Next-state logic; NOPs retire in IDLE without touching the captured request.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    ea_d      = ea_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !in_is_nop) begin
          ctrl_d.is_load  = in_is_load;
          ctrl_d.zero_ext = in_zero_ext;
          ctrl_d.misalign = misalign_in;
          ctrl_d.size     = in_size;
          ctrl_d.rd       = in_rd;
          ea_d            = ea_full[ADDR_W-1:0];
          wdata_d         = in_rs2_val;
          state_d         = misalign_in ? ST_WB : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (mem_rsp_valid) begin
          if (ctrl_q.is_load) begin
            wb_data_d = (ctrl_q.rd == 5'd0) ? '0 : ld_data;
            state_d   = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = {ea_q[ADDR_W-1:2], 2'b00};
  assign mem_we        = mem_req_valid && !ctrl_q.is_load;
  assign mem_wstrb     = mem_we ? strb_raw : 4'b0000;
  assign wb_valid      = (state_q == ST_WB) && !ctrl_q.misalign;
  assign wb_rd         = ctrl_q.rd;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed vectors push expected memory
// requests / writebacks / exceptions; a negedge monitor pops and compares.
module tb_lsu_mem_access;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_zero_ext, in_is_nop;
  logic [1:0]  in_size;
  logic [31:0] in_rs1_val, in_rs2_val;
  logic [4:0]  in_rd;
  logic [11:0] in_imm;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [31:0] exc_addr;

  lsu_mem_access #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_zero_ext(in_zero_ext), .in_is_nop(in_is_nop), .in_size(in_size),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rd(in_rd), .in_imm(in_imm),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_addr(exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] data;
  } req_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  req_exp_t    req_q[$];
  wb_exp_t     wb_q[$];
  logic [31:0] exc_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int exp_hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic exp_req(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
    req_exp_t r;
    r.addr = a; r.we = we; r.strb = s; r.data = d;
    req_q.push_back(r);
    exp_hs++;
  endtask

  task automatic exp_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_exp_t w;
    w.rd = rd; w.data = d;
    wb_q.push_back(w);
  endtask

  // Monitor: compare every DUT-presented event against the scoreboard head.
  always @(negedge clk) begin
    req_exp_t r;
    wb_exp_t  w;
    logic [31:0] ea;
    if (rst_n) begin
      if (mem_req_valid && mem_req_ready) begin
        hs_cnt++;
        if (req_q.size() == 0) note_fail("unexpected_req");
        else begin
          r = req_q.pop_front();
          chk("req_addr", mem_addr, r.addr);
          chk("req_we", {31'b0, mem_we}, {31'b0, r.we});
          if (r.we) begin
            chk("req_wstrb", {28'b0, mem_wstrb}, {28'b0, r.strb});
            chk("req_wdata", mem_wdata, r.data);
          end
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) note_fail("unexpected_wb");
        else begin
          w = wb_q.pop_front();
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, w.rd});
          chk("wb_data", wb_data, w.data);
        end
      end
      if (exc_valid) begin
        if (exc_q.size() == 0) note_fail("unexpected_exc");
        else begin
          ea = exc_q.pop_front();
          chk("exc_addr", exc_addr, ea);
        end
      end
    end
  end

  task automatic wait_idle(input bit no_req);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (no_req) chk("no_mem_req", {31'b0, mem_req_valid}, 32'd0);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: in_ready never returned");
    end
  endtask

  // Issue one decoded op and play the memory side; expectations are pushed by the caller.
  task automatic op(input logic ld, input logic zx, input logic nop, input logic [1:0] sz,
                    input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                    input logic [11:0] imm, input logic [31:0] rdata, input int stall,
                    input bit use_mem);
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_is_load = ld; in_zero_ext = zx; in_is_nop = nop; in_size = sz;
    in_rs1_val = rs1; in_rs2_val = rs2; in_rd = rd; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_nop = 1'b0;
    if (use_mem) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_req_valid", {31'b0, mem_req_valid}, 32'd1);
        if (i == 0) begin
          a0 = mem_addr; s0 = mem_wstrb; d0 = mem_wdata;
        end else begin
          chk("bp_addr_stable", mem_addr, a0);
          chk("bp_wstrb_stable", {28'b0, mem_wstrb}, {28'b0, s0});
          chk("bp_wdata_stable", mem_wdata, d0);
        end
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = rdata;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
    end
    wait_idle(!use_mem);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_zero_ext = 1'b0; in_is_nop = 1'b0;
    in_size = 2'd0; in_rs1_val = '0; in_rs2_val = '0; in_rd = '0; in_imm = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_exc_valid", {31'b0, exc_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SW 0xDEADBEEF -> 0x1004
    exp_req(32'h0000_1004, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    op(1'b0, 1'b0, 1'b0, 2'd2, 32'h1000, 32'hDEAD_BEEF, 5'd0, 12'd4, 32'h0, 0, 1'b1);

    // LB / LBU at 0x2003
    exp_req(32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd5, 32'hFFFF_FF80);
    op(1'b1, 1'b0, 1'b0, 2'd0, 32'h2000, 32'h0, 5'd5, 12'd3, 32'h80FF_0000, 0, 1'b1);
    exp_req(32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd6, 32'h0000_0080);
    op(1'b1, 1'b1, 1'b0, 2'd0, 32'h2000, 32'h0, 5'd6, 12'd3, 32'h80FF_0000, 0, 1'b1);

    // LH with negative offset: 0x3000 - 2 = 0x2FFE
    exp_req(32'h0000_2FFC, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd7, 32'hFFFF_8001);
    op(1'b1, 1'b0, 1'b0, 2'd1, 32'h3000, 32'h0, 5'd7, 12'hFFE, 32'h8001_1234, 0, 1'b1);

    // SB at lane 1, SH at lane 2
    exp_req(32'h0000_0100, 1'b1, 4'b0010, 32'h7878_7878);
    op(1'b0, 1'b0, 1'b0, 2'd0, 32'h100, 32'h1234_5678, 5'd0, 12'd1, 32'h0, 0, 1'b1);
    exp_req(32'h0000_0200, 1'b1, 4'b1100, 32'hCCDD_CCDD);
    op(1'b0, 1'b0, 1'b0, 2'd1, 32'h200, 32'hAABB_CCDD, 5'd0, 12'd2, 32'h0, 0, 1'b1);

    // LHU lane 0, LW to x0, size 3 treated as word
    exp_req(32'h0000_0300, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd8, 32'h0000_F00D);
    op(1'b1, 1'b1, 1'b0, 2'd1, 32'h300, 32'h0, 5'd8, 12'd0, 32'h1234_F00D, 0, 1'b1);
    exp_req(32'h0000_0040, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd0, 32'h0);
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 5'd0, 12'd0, 32'hCAFE_BABE, 0, 1'b1);
    exp_req(32'h0000_0400, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd9, 32'h1122_3344);
    op(1'b1, 1'b0, 1'b0, 2'd3, 32'h400, 32'h0, 5'd9, 12'd0, 32'h1122_3344, 0, 1'b1);

    // Address wrap: 0 + (-4)
    exp_req(32'hFFFF_FFFC, 1'b1, 4'b1111, 32'h0102_0304);
    op(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0102_0304, 5'd0, 12'hFFC, 32'h0, 0, 1'b1);

    // Back-pressure: 5 cycles without mem_req_ready
    exp_req(32'h0000_0508, 1'b1, 4'b1111, 32'h0BAD_F00D);
    op(1'b0, 1'b0, 1'b0, 2'd2, 32'h500, 32'h0BAD_F00D, 5'd0, 12'd8, 32'h0, 5, 1'b1);

    // NOP: no traffic, ready again next cycle
    op(1'b1, 1'b0, 1'b1, 2'd2, 32'h600, 32'h0, 5'd3, 12'd0, 32'h0, 0, 1'b0);
    chk("nop_in_ready", {31'b0, in_ready}, 32'd1);
    chk("nop_wb_valid", {31'b0, wb_valid}, 32'd0);

    // Misaligned word at 0x1002
`ifdef LSU_MISALIGN_TRAP_EN
    exc_q.push_back(32'h0000_1002);
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 5'd10, 12'd2, 32'h5566_7788, 0, 1'b0);
`else
    exp_req(32'h0000_1000, 1'b0, 4'b0000, 32'h0);
    exp_wb(5'd10, 32'h5566_7788);
    op(1'b1, 1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 5'd10, 12'd2, 32'h5566_7788, 0, 1'b1);
`endif

    // Reset while in RSP; the late response must be dropped
    exp_req(32'h0000_0700, 1'b0, 4'b0000, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_is_load = 1'b1; in_zero_ext = 1'b0; in_size = 2'd2;
    in_rs1_val = 32'h700; in_rd = 5'd11; in_imm = 12'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("midrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_wb_rd", {27'b0, wb_rd}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hFACE_FACE;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_rsp_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("late_rsp_in_ready", {31'b0, in_ready}, 32'd1);
    end

    repeat (2) @(negedge clk);
    chk("req_queue_empty", req_q.size(), 32'd0);
    chk("wb_queue_empty", wb_q.size(), 32'd0);
    chk("exc_queue_empty", exc_q.size(), 32'd0);
    chk("handshake_count", hs_cnt, exp_hs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
